// File: rtl/pll_lock_reset_gen.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_gen
//
// Sequences the PLL reset and standby controls, qualifies the asynchronous PLL
// lock indication, and generates the active-low system reset for the UART loop
// logic. Runs on the free-running PLL reference clock, never on the PLL output.
// If lock never arrives (the simulation PLL model never asserts extlock), a
// timeout either releases the system anyway or restarts the PLL reset pulse.
//
// Ports:
//   clk          in   reference clock (PLL refclk)
//   reset        in   synchronous, active-high reset
//   extlock      in   PLL lock indication, asynchronous to clk
//   stdby_req    in   standby request, level, synchronous to clk
//   pll_reset    out  PLL reset, active-high
//   pll_stdby    out  PLL standby
//   sys_rst_n    out  system reset, active-low
//   locked       out  high only in RUN
//   lock_timeout out  sticky timeout flag, cleared only by reset
//   lock_lost    out  one-cycle pulse when lock drops in RUN
//   state        out  current FSM state encoding (debug)
//
// Every output is a flop whose next value is decoded from the next state, so
// outputs change on the same edge as the state register and no input has a
// combinational path to an output.
// -----------------------------------------------------------------------------
module pll_lock_reset_gen #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int STABLE_CYCLES      = 1024,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int RELEASE_ON_TIMEOUT = 1,
  parameter int CNT_W              = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       stdby_req,
  output logic       pll_reset,
  output logic       pll_stdby,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       lock_timeout,
  output logic       lock_lost,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    TO_RUN    = 3'd4,
    STANDBY   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam state_t           TO_DEST  =
    (RELEASE_ON_TIMEOUT != 0) ? TO_RUN : PLL_RST;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             cur_state, nxt_state;
  logic [CNT_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0]   to_cnt, to_cnt_nxt, to_cnt_inc;
  logic [CNT_W-1:0]   stb_cnt, stb_cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               extlock_s;
  logic               timeout_hit;
  logic               set_timeout;
  logic               lost_nxt;
  logic               pll_reset_nxt, pll_stdby_nxt, sys_rst_n_nxt, locked_nxt;

  // ---------------------------------------------------------------------------
  // Lock synchronizer. extlock means nothing while the PLL is held in reset or
  // standby, so the chain is held clear whenever pll_reset is driven; a stale
  // lock from before the reset pulse can therefore never shorten qualification.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset || pll_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], extlock};
    end
  end

  assign extlock_s   = sync_q[SYNC_STAGES-1];
  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);
  // Saturating increment: with the timeout disabled to_cnt must not wrap.
  assign to_cnt_inc  = (to_cnt == '1) ? to_cnt : to_cnt + CNT_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    nxt_state   = cur_state;
    rst_cnt_nxt = rst_cnt;
    to_cnt_nxt  = to_cnt;
    stb_cnt_nxt = stb_cnt;
    set_timeout = 1'b0;
    lost_nxt    = 1'b0;

    if (stdby_req) begin
      nxt_state = STANDBY;
    end else begin
      case (cur_state)
        PLL_RST: begin
          if (rst_cnt == RST_LAST) nxt_state = WAIT_LOCK;
          else                     rst_cnt_nxt = rst_cnt + CNT_ONE;
        end

        WAIT_LOCK: begin
          if (timeout_hit) begin
            set_timeout = 1'b1;
            nxt_state   = TO_DEST;
          end else begin
            to_cnt_nxt = to_cnt_inc;
            if (extlock_s) begin
              nxt_state   = STABLE;
              stb_cnt_nxt = '0;
            end
          end
        end

        STABLE: begin
          // Order matters: a completed qualification beats the timeout, and
          // the timeout beats a lock drop; a drop on the terminal cycle falls
          // through to the abort branch because extlock_s is low.
          if (extlock_s && (stb_cnt == STB_LAST)) begin
            nxt_state = RUN;
          end else if (timeout_hit) begin
            set_timeout = 1'b1;
            nxt_state   = TO_DEST;
          end else begin
            to_cnt_nxt = to_cnt_inc;
            if (!extlock_s) begin
              nxt_state   = WAIT_LOCK;
              stb_cnt_nxt = '0;
            end else begin
              stb_cnt_nxt = stb_cnt + CNT_ONE;
            end
          end
        end

        RUN: begin
          if (!extlock_s) begin
            nxt_state = PLL_RST;
            lost_nxt  = 1'b1;
          end
        end

        // Timeout release is final until standby or reset; extlock ignored.
        TO_RUN: nxt_state = TO_RUN;

        // stdby_req is low on this path, so standby is being released.
        STANDBY: nxt_state = PLL_RST;

        default: nxt_state = PLL_RST;
      endcase
    end

    // Every entry into PLL_RST restarts both the reset pulse and the timeout.
    if ((nxt_state == PLL_RST) && (cur_state != PLL_RST)) begin
      rst_cnt_nxt = '0;
      to_cnt_nxt  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state; registered below.
  // ---------------------------------------------------------------------------
  always_comb begin
    pll_reset_nxt = 1'b0;
    pll_stdby_nxt = 1'b0;
    sys_rst_n_nxt = 1'b0;
    locked_nxt    = 1'b0;
    case (nxt_state)
      PLL_RST: pll_reset_nxt = 1'b1;
      RUN: begin
        sys_rst_n_nxt = 1'b1;
        locked_nxt    = 1'b1;
      end
      TO_RUN:  sys_rst_n_nxt = 1'b1;
      STANDBY: begin
        pll_reset_nxt = 1'b1;
        pll_stdby_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= PLL_RST;
      rst_cnt      <= '0;
      to_cnt       <= '0;
      stb_cnt      <= '0;
      pll_reset    <= 1'b1;
      pll_stdby    <= 1'b0;
      sys_rst_n    <= 1'b0;
      locked       <= 1'b0;
      lock_timeout <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      rst_cnt      <= rst_cnt_nxt;
      to_cnt       <= to_cnt_nxt;
      stb_cnt      <= stb_cnt_nxt;
      pll_reset    <= pll_reset_nxt;
      pll_stdby    <= pll_stdby_nxt;
      sys_rst_n    <= sys_rst_n_nxt;
      locked       <= locked_nxt;
      lock_timeout <= lock_timeout | set_timeout;
      lock_lost    <= lost_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_reset_gen
//
// Self-checking bench for pll_lock_reset_gen with SYNC_STAGES=2,
// PLL_RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32. dut_a releases on
// timeout; dut_b (extlock tied low) restarts the PLL reset on timeout.
// Inputs change just after a falling edge and outputs are sampled on the
// falling edge, so "edge N" below is the Nth rising edge counted from the
// one that moved the FSM into WAIT_LOCK (W).
// -----------------------------------------------------------------------------
module tb_pll_lock_reset_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       extlock = 1'b0;
  logic       stdby_req = 1'b0;

  logic       pll_reset, pll_stdby, sys_rst_n, locked, lock_timeout, lock_lost;
  logic [2:0] state;

  logic       b_pll_reset, b_pll_stdby, b_sys_rst_n, b_locked;
  logic       b_lock_timeout, b_lock_lost;
  logic [2:0] b_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_lock_reset_gen #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32), .RELEASE_ON_TIMEOUT(1), .CNT_W(17)
  ) dut_a (
    .clk(clk), .reset(reset), .extlock(extlock), .stdby_req(stdby_req),
    .pll_reset(pll_reset), .pll_stdby(pll_stdby), .sys_rst_n(sys_rst_n),
    .locked(locked), .lock_timeout(lock_timeout), .lock_lost(lock_lost),
    .state(state)
  );

  pll_lock_reset_gen #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32), .RELEASE_ON_TIMEOUT(0), .CNT_W(17)
  ) dut_b (
    .clk(clk), .reset(reset), .extlock(1'b0), .stdby_req(1'b0),
    .pll_reset(b_pll_reset), .pll_stdby(b_pll_stdby), .sys_rst_n(b_sys_rst_n),
    .locked(b_locked), .lock_timeout(b_lock_timeout), .lock_lost(b_lock_lost),
    .state(b_state)
  );

  typedef struct packed {
    logic       rst;
    logic       ext;
    logic       stby;
    logic [2:0] st;
    logic       pr;
    logic       sd;
    logic       sr;
    logic       lk;
    logic       ll;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic rst, input logic ext, input logic stby,
                     input logic [2:0] st, input logic pr, input logic sd,
                     input logic sr, input logic lk, input logic ll,
                     input logic to);
    vecs.push_back('{rst, ext, stby, st, pr, sd, sr, lk, ll, to});
  endtask

  // Ticks until dut_a reports WAIT_LOCK; returns sampled just after edge W.
  task automatic wait_wait_lock();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (state == 3'd1) found = 1'b1;
    end
    check("wait_lock_entry", {31'd0, found}, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // -------------------------------------------------------------------------
    // Table: reset, lock with extlock tied high, then lock loss in RUN.
    // Fields: rst ext stby | state pll_reset pll_stdby sys_rst_n locked
    //                        lock_lost lock_timeout (after the edge)
    // -------------------------------------------------------------------------
    add(1, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0);          // reset edge: pulse cycle 1
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0);        // pulse cycles 2..4
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 0);        // W, W+1 (sync), W+2
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 3'd2, 0, 0, 0, 0, 0, 0);        // STABLE W+3..W+10
    for (int i = 0; i < 2; i++)
      add(0, 1, 0, 3'd3, 0, 0, 1, 1, 0, 0);        // RUN from W+11
    for (int i = 0; i < 2; i++)
      add(0, 0, 0, 3'd3, 0, 0, 1, 1, 0, 0);        // drop travels the sync chain
    add(0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 0);          // lock_lost pulse, 2 edges on
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0);        // pulse is one cycle only
    add(0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 0);          // sequence restarts

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      extlock   = vecs[i].ext;
      stdby_req = vecs[i].stby;
      tick();
      check($sformatf("vec%0d", i),
            {23'd0, state, pll_reset, pll_stdby, sys_rst_n, locked, lock_lost,
             lock_timeout},
            {23'd0, vecs[i].st, vecs[i].pr, vecs[i].sd, vecs[i].sr, vecs[i].lk,
             vecs[i].ll, vecs[i].to});
    end

    // -------------------------------------------------------------------------
    // Lock glitch during STABLE: high 5, low 1, high again (final rise at W+6).
    // -------------------------------------------------------------------------
    extlock = 1'b0;
    pulse_reset();
    wait_wait_lock();
    extlock = 1'b1;
    repeat (5) tick();
    extlock = 1'b0;
    tick();
    extlock = 1'b1;
    repeat (2) tick();                              // W+8
    check("glitch_abort_state", state, 3'd1);
    repeat (8) tick();                              // W+16
    check("glitch_rst_n_before", sys_rst_n, 1'b0);
    tick();                                         // W+17 = final rise + 11
    check("glitch_rst_n_release", sys_rst_n, 1'b1);
    check("glitch_state_run", state, 3'd3);
    check("glitch_no_timeout", lock_timeout, 1'b0);

    // -------------------------------------------------------------------------
    // No lock: dut_a releases on timeout, dut_b re-pulses the PLL reset.
    // -------------------------------------------------------------------------
    extlock = 1'b0;
    pulse_reset();
    wait_wait_lock();
    repeat (31) tick();                             // W+31
    check("to_a_before_state", state, 3'd1);
    check("to_a_before_flag", lock_timeout, 1'b0);
    check("to_b_before_state", b_state, 3'd1);
    tick();                                         // W+32
    check("to_a_flag", lock_timeout, 1'b1);
    check("to_a_rst_n", sys_rst_n, 1'b1);
    check("to_a_locked", locked, 1'b0);
    check("to_a_state", state, 3'd4);
    check("to_b_state", b_state, 3'd0);
    check("to_b_pll_reset", b_pll_reset, 1'b1);
    check("to_b_flag", b_lock_timeout, 1'b1);
    check("to_b_rst_n", b_sys_rst_n, 1'b0);
    extlock = 1'b1;                                 // ignored in TO_RUN
    repeat (3) tick();                              // W+35
    check("to_b_pulse_last", b_pll_reset, 1'b1);
    tick();                                         // W+36
    check("to_b_pulse_end", b_pll_reset, 1'b0);
    check("to_b_rewait", b_state, 3'd1);
    repeat (31) tick();                             // W+67
    check("to_b_second_wait", b_state, 3'd1);
    tick();                                         // W+68
    check("to_b_second_timeout", b_state, 3'd0);
    check("to_b_second_pulse", b_pll_reset, 1'b1);
    check("to_a_holds", state, 3'd4);
    check("to_a_holds_rst_n", sys_rst_n, 1'b1);

    // -------------------------------------------------------------------------
    // Reset from TO_RUN clears the sticky flag.
    // -------------------------------------------------------------------------
    extlock = 1'b0;
    reset   = 1'b1;
    tick();
    check("rst_clears_flag", lock_timeout, 1'b0);
    check("rst_state", state, 3'd0);
    check("rst_rst_n", sys_rst_n, 1'b0);
    reset = 1'b0;

    // -------------------------------------------------------------------------
    // Lock drop seen on the STABLE terminal cycle (stb_cnt=7 after W+10).
    // -------------------------------------------------------------------------
    wait_wait_lock();
    extlock = 1'b1;
    repeat (8) tick();                              // W+8
    extlock = 1'b0;                                 // sampled at W+9 only
    tick();
    extlock = 1'b1;
    tick();                                         // W+10
    check("term_still_stable", state, 3'd2);
    tick();                                         // W+11
    check("term_drop_wins", state, 3'd1);
    check("term_no_release", sys_rst_n, 1'b0);
    repeat (8) tick();                              // W+19
    check("term_restable", state, 3'd2);
    tick();                                         // W+20
    check("term_run", state, 3'd3);
    check("term_locked", locked, 1'b1);

    // -------------------------------------------------------------------------
    // Standby from RUN, release, then standby from STABLE and a full relock.
    // -------------------------------------------------------------------------
    stdby_req = 1'b1;
    tick();
    check("sb_run_stdby", pll_stdby, 1'b1);
    check("sb_run_pll_reset", pll_reset, 1'b1);
    check("sb_run_rst_n", sys_rst_n, 1'b0);
    check("sb_run_state", state, 3'd5);
    tick();
    check("sb_run_hold", state, 3'd5);
    stdby_req = 1'b0;
    tick();                                         // E
    check("sb_rel_state", state, 3'd0);
    check("sb_rel_stdby", pll_stdby, 1'b0);
    repeat (3) tick();                              // E+3
    check("sb_rel_pulse_last", pll_reset, 1'b1);
    tick();                                         // E+4
    check("sb_rel_wait", state, 3'd1);
    check("sb_rel_pulse_end", pll_reset, 1'b0);
    repeat (3) tick();                              // E+7
    check("sb_stable_entry", state, 3'd2);
    tick();
    stdby_req = 1'b1;
    tick();
    check("sb_stable_state", state, 3'd5);
    check("sb_stable_stdby", pll_stdby, 1'b1);
    check("sb_stable_rst_n", sys_rst_n, 1'b0);
    stdby_req = 1'b0;
    tick();                                         // F
    check("sb2_rel_state", state, 3'd0);
    repeat (4) tick();                              // F+4
    check("sb2_wait", state, 3'd1);
    repeat (10) tick();                             // F+14
    check("sb2_rst_n_before", sys_rst_n, 1'b0);
    tick();                                         // F+15
    check("sb2_rst_n_release", sys_rst_n, 1'b1);
    check("sb2_state_run", state, 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_gen.md
Name: pll_lock_reset_gen

Overview:
- Sequences PLL reset and standby, qualifies the PLL `extlock` output, and generates the active-low system reset `sys_rst_n` for the UART loop logic.
- Sits directly downstream of the pll instance.
- Runs on the free-running reference clock (the PLL refclk), not on the PLL output.
- Timeout fallback releases the system even if lock never arrives; the simulation PLL model never asserts `extlock`.

Parameters:
- SYNC_STAGES, 2: flop stages on the asynchronous `extlock` input (min 2).
- PLL_RST_CYCLES, 16: cycles `pll_reset` is held in PLL_RST (min 1).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (min 1).
- TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK+STABLE before timeout; 0 disables timeout.
- RELEASE_ON_TIMEOUT, 1: 1 means timeout releases `sys_rst_n`; 0 means timeout restarts at PLL_RST.
- CNT_W, 17: width of the stable and timeout counters; must hold max(STABLE_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES).

Ports:
- clk  in  1  reference clock.
- reset  in  1  synchronous, active-high reset.
- extlock  in  1  PLL lock indication, asynchronous.
- stdby_req  in  1  standby request, synchronous to `clk`, level.
- pll_reset  out  1  drives PLL `reset`, active-high.
- pll_stdby  out  1  drives PLL `stdby`.
- sys_rst_n  out  1  system reset, active-low.
- locked  out  1  high only in RUN.
- lock_timeout  out  1  sticky timeout flag; cleared only by `reset`.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- state  out  3  current FSM state encoding, for debug.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values:
  - state = PLL_RST; counters = 0; sync chain = 0.
  - pll_reset = 1, pll_stdby = 0, sys_rst_n = 0.
  - locked = 0, lock_timeout = 0, lock_lost = 0.
- `extlock_s` is `extlock` after SYNC_STAGES flops. All decisions use `extlock_s` only.
- State encoding: PLL_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, TO_RUN = 4, STANDBY = 5.
- Priority: `reset` > `stdby_req` > all other transitions.
- Any state with stdby_req = 1: next state is STANDBY.
- PLL_RST:
  - pll_reset = 1, sys_rst_n = 0.
  - rst_cnt counts 0..PLL_RST_CYCLES-1.
  - At terminal count, go to WAIT_LOCK.
  - Entry from any state clears rst_cnt and to_cnt.
- WAIT_LOCK:
  - pll_reset = 0, sys_rst_n = 0; to_cnt increments.
  - extlock_s = 1: go to STABLE with stb_cnt = 0.
- STABLE:
  - stb_cnt increments while extlock_s = 1.
  - extlock_s = 0: go back to WAIT_LOCK; stb_cnt cleared, to_cnt keeps running.
  - stb_cnt == STABLE_CYCLES-1 with extlock_s = 1: go to RUN.
  - A lock drop on that same terminal cycle wins: go to WAIT_LOCK.
- Timeout:
  - Fires when TIMEOUT_CYCLES != 0 and to_cnt == TIMEOUT_CYCLES-1 in WAIT_LOCK or STABLE.
  - A simultaneous STABLE-to-RUN transition wins over timeout.
  - On timeout, lock_timeout is set to 1 (sticky).
  - Next state is TO_RUN if RELEASE_ON_TIMEOUT = 1, else PLL_RST.
- RUN:
  - sys_rst_n = 1, locked = 1.
  - extlock_s = 0: lock_lost pulses 1 for one cycle, locked = 0, sys_rst_n = 0, next state PLL_RST.
- TO_RUN:
  - sys_rst_n = 1, locked = 0; `extlock` is ignored.
  - Leaves only via stdby_req or reset.
- STANDBY:
  - pll_stdby = 1, pll_reset = 1, sys_rst_n = 0, locked = 0.
  - stdby_req = 0: go to PLL_RST.
- Output timing: outputs take their new-state values in the same cycle the state register updates.
- Latency: `extlock` rising on edge t gives sys_rst_n = 1 at t + SYNC_STAGES + STABLE_CYCLES + 1, provided lock stays high and no stdby_req.
- Counters never wrap: each saturates at its terminal value or clears on state exit.
- Reset asserted mid-operation returns everything to reset values on the next edge, including lock_timeout.

Test Plan (SYNC_STAGES = 2, PLL_RST_CYCLES = 4, STABLE_CYCLES = 8, TIMEOUT_CYCLES = 32 unless noted):
1. Reset released, `extlock` tied high → pll_reset high for exactly 4 cycles; sys_rst_n rises exactly 2 + 8 + 1 cycles after WAIT_LOCK entry; locked = 1; state = 3.
2. `extlock` high 5 cycles, low 1 cycle, then high → STABLE aborts to WAIT_LOCK; sys_rst_n rises 11 cycles after the final rise; lock_timeout stays 0.
3. `extlock` tied low (simulation PLL model), RELEASE_ON_TIMEOUT = 1 → 32 cycles after WAIT_LOCK entry: lock_timeout = 1, sys_rst_n = 1, locked = 0, state = 4. With RELEASE_ON_TIMEOUT = 0 → state returns to PLL_RST and pll_reset re-pulses for 4 cycles, repeatedly.
4. In RUN, drop `extlock` → 2 cycles later lock_lost pulses for exactly 1 cycle, sys_rst_n = 0, pll_reset = 1, full sequence repeats.
5. stdby_req = 1 in RUN and in STABLE → next cycle pll_stdby = 1, pll_reset = 1, sys_rst_n = 0. On release → PLL_RST for 4 cycles, then normal relock.
6. Assert reset in TO_RUN → next edge: lock_timeout = 0, state = 0, sys_rst_n = 0. `extlock` toggling on the STABLE terminal cycle → WAIT_LOCK, not RUN.
